// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM master arbiter and the requesters around it.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } arb_state_e;

    localparam int ADDR_W_DEF      = 24;
    localparam int DATA_W_DEF      = 32;
    localparam int SDRAM_WORD_SKIP = 4;

endpackage

// File: rtl/sdram_master_arbiter_if.sv
// Bundle of requester-side handshakes and Avalon-MM master pins around the arbiter.
interface sdram_master_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 5
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_accept;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_accept;
    logic [ADDR_W-1:0] sdaddress;
    logic              sdread;
    logic              sdwrite;
    logic [DATA_W-1:0] sdwritedata;
    logic [DATA_W-1:0] sdreaddata;
    logic              sdreaddatavalid;
    logic              sdwaitrequest;
    logic [CNT_W-1:0]  outstanding;
    logic              err_underflow;

    modport master (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  sdreaddata, sdreaddatavalid, sdwaitrequest,
        output rd_accept, rd_data, rd_valid, wr_accept,
        output sdaddress, sdread, sdwrite, sdwritedata,
        output outstanding, err_underflow
    );

    modport slave (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output sdreaddata, sdreaddatavalid, sdwaitrequest,
        input  rd_accept, rd_data, rd_valid, wr_accept,
        input  sdaddress, sdread, sdwrite, sdwritedata,
        input  outstanding, err_underflow
    );

endinterface

// File: rtl/sdram_credit_counter.sv
// Outstanding-read credit counter with saturation and a sticky underflow flag.
module sdram_credit_counter #(
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_W           = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             err_underflow_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        // A return with nothing outstanding means the slave and our bookkeeping disagree.
        if (dec_i && (count_q == '0)) begin
            err_d = 1'b1;
        end
        if (inc_i && !dec_i) begin
            if (count_q != CNT_W'(MAX_OUTSTANDING)) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (dec_i && !inc_i) begin
            if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count_o         = count_q;
    assign err_underflow_o = err_q;

endmodule

// File: rtl/sdram_master_arbiter.sv
// Arbitrates the single SDRAM Avalon-MM master between read-fetch and result-write engines,
// with read credit tracking and bounded write starvation.
module sdram_master_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int DATA_W          = DATA_W_DEF,
    parameter int MAX_OUTSTANDING = 16,
    parameter int STARVE_LIMIT    = 8,
    parameter int CNT_W           = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    sdram_master_arbiter_if.master bus
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_READ  = READ;
    localparam logic [1:0] ST_WRITE = WRITE;
    localparam int         STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [1:0]          state_q, state_d;
    logic [ADDR_W-1:0]   sdaddress_q, sdaddress_d;
    logic [DATA_W-1:0]   sdwritedata_q, sdwritedata_d;
    logic                sdread_q, sdread_d;
    logic                sdwrite_q, sdwrite_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic [CNT_W-1:0]    outstanding;
    logic                rd_elig, rd_grant, wr_grant, rd_accept, wr_accept;

    always_comb begin
        rd_elig   = bus.rd_req && (outstanding < CNT_W'(MAX_OUTSTANDING));
        wr_grant  = (state_q == ST_IDLE) && bus.wr_req &&
                    (!rd_elig || (starve_q == STARVE_W'(STARVE_LIMIT)));
        rd_grant  = (state_q == ST_IDLE) && rd_elig && !wr_grant;
        rd_accept = (state_q == ST_READ) && !bus.sdwaitrequest;
        wr_accept = (state_q == ST_WRITE) && !bus.sdwaitrequest;
    end

    always_comb begin
        state_d       = state_q;
        sdaddress_d   = sdaddress_q;
        sdwritedata_d = sdwritedata_q;
        sdread_d      = sdread_q;
        sdwrite_d     = sdwrite_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_grant) begin
                    sdaddress_d   = bus.wr_addr;
                    sdwritedata_d = bus.wr_data;
                    sdwrite_d     = 1'b1;
                    state_d       = ST_WRITE;
                end else if (rd_grant) begin
                    sdaddress_d = bus.rd_addr;
                    sdread_d    = 1'b1;
                    state_d     = ST_READ;
                end
            end
            ST_READ: begin
                if (rd_accept) begin
                    sdread_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (wr_accept) begin
                    sdwrite_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                sdread_d  = 1'b0;
                sdwrite_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Count consecutive read grants only while a write is actually waiting.
    always_comb begin
        starve_d = starve_q;
        if (!bus.wr_req || wr_grant) begin
            starve_d = '0;
        end else if (rd_grant && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            sdaddress_q   <= '0;
            sdwritedata_q <= '0;
            sdread_q      <= 1'b0;
            sdwrite_q     <= 1'b0;
            starve_q      <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sdaddress_q   <= sdaddress_d;
            sdwritedata_q <= sdwritedata_d;
            sdread_q      <= sdread_d;
            sdwrite_q     <= sdwrite_d;
            starve_q      <= starve_d;
            rd_data_q     <= bus.sdreaddata;
            rd_valid_q    <= bus.sdreaddatavalid;
        end
    end

    sdram_credit_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_credit (
        .clk             (clk),
        .reset           (reset),
        .inc_i           (rd_accept),
        .dec_i           (bus.sdreaddatavalid),
        .count_o         (outstanding),
        .err_underflow_o (bus.err_underflow)
    );

    assign bus.rd_accept   = rd_accept;
    assign bus.wr_accept   = wr_accept;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.sdaddress   = sdaddress_q;
    assign bus.sdwritedata = sdwritedata_q;
    assign bus.sdread      = sdread_q;
    assign bus.sdwrite     = sdwrite_q;
    assign bus.outstanding = outstanding;

endmodule

// File: doc/sdram_master_arbiter.md
Name: sdram_master_arbiter

Overview:
Shares the single SDRAM Avalon-MM master port between the filter's read-fetch engine and its result-write engine. Grants one transaction at a time and tracks outstanding pipelined reads against a credit limit. Forwards returning read data to the read requester and prevents write starvation under continuous read demand. Sits between the filter core's request logic and the sdaddress/sdread/sdwrite master pins.

Parameters:
ADDR_W, 24, SDRAM word address width
DATA_W, 32, data width
MAX_OUTSTANDING, 16, maximum accepted-but-unreturned reads (matches request FIFO depth)
STARVE_LIMIT, 8, maximum consecutive read grants while wr_req is pending
CNT_W, 5, width of outstanding counter (must hold MAX_OUTSTANDING)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
rd_req  in  1  read requester wants a transfer; hold with rd_addr until rd_accept
rd_addr  in  ADDR_W  read address
rd_accept  out  1  combinational; high in the cycle the slave accepts the read
rd_data  out  DATA_W  returned read data (registered)
rd_valid  out  1  rd_data valid (registered 1-cycle pulse per beat)
wr_req  in  1  write requester wants a transfer; hold with wr_addr/wr_data until wr_accept
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_accept  out  1  combinational; high in the cycle the slave accepts the write
sdaddress  out  ADDR_W  master address (registered)
sdread  out  1  master read (registered)
sdwrite  out  1  master write (registered)
sdwritedata  out  DATA_W  master write data (registered)
sdreaddata  in  DATA_W  slave read data
sdreaddatavalid  in  1  slave read data valid
sdwaitrequest  in  1  slave stall
outstanding  out  CNT_W  current outstanding read count
err_underflow  out  1  sticky: readdatavalid seen with outstanding==0

Behaviour:
- Reset: state IDLE; sdread, sdwrite, rd_valid, err_underflow = 0; sdaddress, sdwritedata, rd_data = 0; outstanding = 0; starve count = 0. Reset mid-transaction drops sdread/sdwrite on the next edge.
- Clock enable is unconditional.
- States: IDLE, READ, WRITE.
- IDLE, read eligible = rd_req && outstanding < MAX_OUTSTANDING.
- IDLE, write wins when wr_req && (!read eligible || starve == STARVE_LIMIT).
- IDLE, otherwise read wins when read eligible.
- On a grant, the next edge registers sdaddress (plus sdwritedata for a write), raises sdread or sdwrite, and enters READ or WRITE. Request-to-pin latency is 1 cycle.
- READ/WRITE: hold all master outputs stable while sdwaitrequest is high.
- When sdwaitrequest is low, rd_accept or wr_accept is high that cycle. The next edge drops the strobe and returns to IDLE.
- There is always at least one IDLE cycle between transactions, so peak rate is 1 transfer per 2 cycles.
- Starve count increments on each read grant made while wr_req is high. It clears on a write grant or whenever wr_req is low. It saturates at STARVE_LIMIT.
- Outstanding counter:
  - +1 on read accept, -1 on sdreaddatavalid; simultaneous events leave it unchanged.
  - sdreaddatavalid at 0 keeps it at 0 and sets err_underflow, which is cleared only by reset.
- Read return: rd_data <= sdreaddata and rd_valid <= sdreaddatavalid every cycle, 1-cycle latency, in slave order.
  - Return data is never dropped or back-pressured; the consumer must have MAX_OUTSTANDING slots of space.
- Writes may be granted while reads are outstanding; the slave preserves order.
- rd_req or wr_req deasserted mid-transaction (protocol violation) is ignored: the transaction in flight completes.

Decomposition:
- Shared package sdram_arb_pkg holds:
  - state enum {IDLE, READ, WRITE};
  - ADDR_W/DATA_W defaults;
  - the SDRAM_WORD_SKIP constant (4), used by the requesters.
- One natural sub-module, sdram_credit_counter: the outstanding up/down counter with saturation and the underflow flag. The rest stays in a single module.

Test Plan:
- Single read: rd_req with addr 0x000100 and waitrequest low -> sdread high one cycle later with sdaddress 0x000100, rd_accept in that cycle, outstanding=1. Valid return of 0x000000AB 3 cycles later -> rd_valid with rd_data 0xAB one cycle after, outstanding=0.
- Waitrequest stall: write to 0x000200 with data 0x5A and waitrequest high for 4 cycles -> sdwrite, sdaddress and sdwritedata held stable; wr_accept only in the 5th cycle; sdwrite low the next cycle.
- Credit limit: 16 reads accepted with no returns -> 17th rd_req not granted and outstanding=16. One return -> grant resumes. Simultaneous accept and return -> count unchanged.
- Starvation: rd_req and wr_req both held continuously -> exactly 8 read grants, then 1 write grant, then the pattern repeats. wr_req alone -> immediate grant.
- Underflow: sdreaddatavalid with outstanding=0 -> err_underflow=1 sticky, outstanding stays 0, data still forwarded on rd_valid.
- Reset mid-read: assert reset while sdread is high under waitrequest -> sdread=0, outstanding=0, state IDLE after one edge. The next rd_req is granted normally.
